seq_detect_ctrl: RTL

Run controller for serial bit-pattern detection on the single-bit data_in stream, the same stream that feeds seq_101_detect.
- Accepts a start command carrying a programmable pattern, pattern length, sample window and match threshold.
- Sequences one scan run over data_in, counts overlapping matches and reports completion status.
- Sits between the bit-stream source and the status/interrupt logic. Generalises the fixed 101 detector into a configurable, run-based engine.

---
 rtl/seq_detect_ctrl_if.sv | 39 +++
 rtl/seq_detect_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - command, stream and status bundle for seq_detect_ctrl (tmo only with SEQ_DETECT_CTRL_TIMEOUT_EN)
interface seq_detect_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat;
  logic [3:0]       pat_len;
  logic [CNT_W-1:0] window;
  logic [CNT_W-1:0] thresh;
  logic             data_valid;
  logic             data_in;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic             hit;
  logic             err;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  logic             tmo;
`endif

  modport master (
    output start, abort, pat, pat_len, window, thresh, data_valid, data_in,
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    input  tmo,
`endif
    input  busy, match, match_cnt, done, hit, err
  );

  modport slave (
    input  start, abort, pat, pat_len, window, thresh, data_valid, data_in,
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    output tmo,
`endif
    output busy, match, match_cnt, done, hit, err
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run-based programmable serial pattern detector with overlap counting
// Optional idle-gap timeout enabled by SEQ_DETECT_CTRL_TIMEOUT_EN.
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_detect_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SCAN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d;
  logic [3:0]       len_q, len_d;
  logic [CNT_W-1:0] win_q, win_d, thr_q, thr_d;
  logic [CNT_W-1:0] seen_q, seen_d, cnt_q, cnt_d;
  logic             match_q, match_d, hit_q, hit_d, err_q, err_d;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  logic [15:0]      idle_q, idle_d;
  logic             tmo_q, tmo_d;
`endif

  logic [PAT_W-1:0] mask, hist_nx;
  logic [CNT_W-1:0] seen_nx, cnt_nx;
  logic             pat_hit;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_q));
  end

  assign hist_nx = {hist_q[PAT_W-2:0], bus.data_in};
  assign seen_nx = (&seen_q) ? seen_q : seen_q + CNT_W'(1);
  assign cnt_nx  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign pat_hit = (seen_nx >= CNT_W'(len_q)) && ((hist_nx & mask) == (pat_q & mask));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    len_d   = len_q;
    win_d   = win_q;
    thr_d   = thr_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    hit_d   = hit_q;
    err_d   = err_q;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    idle_d  = idle_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pat_d  = bus.pat;
          len_d  = bus.pat_len;
          win_d  = bus.window;
          thr_d  = bus.thresh;
          hist_d = '0;
          seen_d = '0;
          cnt_d  = '0;
          hit_d  = 1'b0;
          err_d  = 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
          tmo_d  = 1'b0;
`endif
          if (bus.pat_len == 4'd0 || int'(bus.pat_len) > PAT_W) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ARM;
          end
        end
      end
      S_ARM: begin
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        idle_d  = '0;
`endif
        state_d = S_SCAN;
      end
      S_SCAN: begin
        // Abort discards any sample presented in the same cycle.
        if (bus.abort) begin
          state_d = S_DONE;
        end else if (bus.data_valid) begin
          hist_d = hist_nx;
          seen_d = seen_nx;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
          idle_d = '0;
`endif
          if (pat_hit) begin
            match_d = 1'b1;
            cnt_d   = cnt_nx;
            if (thr_q != '0 && cnt_nx == thr_q) begin
              hit_d   = 1'b1;
              state_d = S_DONE;
            end
          end
          if (win_q != '0 && seen_nx == win_q) state_d = S_DONE;
        end
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        else if (idle_q + 16'd1 == 16'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          idle_d = idle_q + 16'd1;
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      len_q   <= '0;
      win_q   <= '0;
      thr_q   <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
      idle_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      len_q   <= len_d;
      win_q   <= win_d;
      thr_q   <= thr_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
      idle_q  <= idle_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.busy      = (state_q == S_ARM) || (state_q == S_SCAN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.hit       = hit_q;
  assign bus.err       = err_q;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  assign bus.tmo       = tmo_q;
`endif
endmodule
